// File: rtl/spi_cs_sequencer.sv
// Avalon-MM chip-select sequencer: software target register plus a live select register.
// Drops land one edge after the target write; new selects wait a programmable guard gap.
// Optional macro CS_ONEHOT_EN: the target register holds at most one set bit.
module spi_cs_sequencer #(
  parameter int unsigned CS_W     = 1,
  parameter int unsigned GAP_W    = 8,
  parameter logic [15:0] GAP_RST  = 16'd0,
  parameter logic [31:0] INV_MASK = 32'd0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            chipselect,
  input  logic [1:0]      address,
  input  logic            write_n,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  output logic [CS_W-1:0] out_port
);

  typedef enum logic {S_IDLE = 1'b0, S_GAP = 1'b1} state_t;

  localparam logic [GAP_W-1:0] GAP_INIT = GAP_RST[GAP_W-1:0];
  localparam logic [CS_W-1:0]  INV      = INV_MASK[CS_W-1:0];

  state_t           state, state_nxt;
  logic [CS_W-1:0]  tgt, tgt_wr;
  logic [CS_W-1:0]  act, act_nxt;
  logic [CS_W-1:0]  add;
  logic [GAP_W-1:0] gap;
  logic [GAP_W-1:0] cnt, cnt_nxt;
  logic             tgt_chg;
  logic             wr_en;
  logic [CS_W-1:0]  wd_cs;
  logic             busy;
  logic             unused_wd;

  assign wr_en = chipselect & ~write_n;
  assign wd_cs = writedata[CS_W-1:0];
  // Bits of writedata above the register widths are intentionally dropped.
  assign unused_wd = &{1'b0, writedata};

  // Isolate the lowest set bit (two's-complement trick).
  function automatic logic [CS_W-1:0] lowest_bit(input logic [CS_W-1:0] v);
    return v & (~v + CS_W'(1));
  endfunction

  // Software view: value the target register takes after this edge.
  always_comb begin
    tgt_wr = tgt;
    if (wr_en) begin
      case (address)
`ifdef CS_ONEHOT_EN
        2'd0:    tgt_wr = lowest_bit(wd_cs);
        2'd1:    tgt_wr = (wd_cs != '0) ? lowest_bit(wd_cs) : tgt;
`else
        2'd0:    tgt_wr = wd_cs;
        2'd1:    tgt_wr = tgt | wd_cs;
`endif
        2'd2:    tgt_wr = tgt & ~wd_cs;
        default: tgt_wr = tgt;
      endcase
    end
  end

  // Software registers; tgt_chg lets the sequencer react to a target change one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt     <= '0;
      tgt_chg <= 1'b0;
      gap     <= GAP_INIT;
    end else begin
      tgt     <= tgt_wr;
      tgt_chg <= (tgt_wr != tgt);
      if (wr_en && (address == 2'd3)) begin
        gap <= writedata[GAP_W-1:0];
      end
    end
  end

  // Sequencer state register with live selects and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      act   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      act   <= act_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign add = tgt & ~act;

  // Next-state logic: drops always immediate, adds released when the gap expires.
  always_comb begin
    state_nxt = state;
    act_nxt   = act;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (act != tgt) begin
          act_nxt = act & tgt;
          if (add != '0) begin
            if (gap == '0) begin
              act_nxt = tgt;
            end else begin
              cnt_nxt   = gap;
              state_nxt = S_GAP;
            end
          end
        end
      end
      default: begin
        act_nxt = act & tgt;
        if (add == '0) begin
          // Pending selects were withdrawn: abandon the gap.
          state_nxt = S_IDLE;
        end else if (tgt_chg) begin
          // Target moved mid-gap: restart the guard time; a zero gap releases at once.
          if (gap == '0) begin
            act_nxt   = tgt;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = gap;
          end
        end else if (cnt <= GAP_W'(1)) begin
          act_nxt   = tgt;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - GAP_W'(1);
        end
      end
    endcase
  end

  // Outputs: pin polarity and zero-extended register readback.
  always_comb begin
    busy     = (state == S_GAP);
    out_port = act ^ INV;
    readdata = '0;
    case (address)
      2'd0:    readdata[CS_W-1:0]  = tgt;
      2'd1:    readdata[CS_W-1:0]  = act;
      2'd2:    readdata[0]         = busy;
      default: readdata[GAP_W-1:0] = gap;
    endcase
  end

endmodule
